instruction_memory_responder: RTL and testbench

//   Memory-side responder for the instruction cache block-fetch interface.
//   On a read request it asserts busywait for a fixed latency, then returns one 16-byte block.
//   It also exposes a byte-wide program-load port so the bench or boot logic can fill the array.

---
 rtl/instruction_memory_responder.sv | 108 ++++++++++
 tb/tb_instruction_memory_responder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/instruction_memory_responder.sv
// Block-fetch responder for the instruction cache: holds busywait for LATENCY cycles per
// request, then returns one 16-byte block. A byte-wide load port fills the array while idle.
module instruction_memory_responder #(
  parameter int LATENCY      = 40,
  parameter int BLOCK_ADDR_W = 6,
  parameter int BLOCK_BYTES  = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      read,
  input  logic [BLOCK_ADDR_W-1:0]   address,
  output logic [8*BLOCK_BYTES-1:0]  readdata,
  output logic                      busywait,
  input  logic                      load_en,
  input  logic [BLOCK_ADDR_W+3:0]   load_addr,
  input  logic [7:0]                load_data,
  output logic                      load_err,
  output logic [1:0]                state_dbg
);

  localparam int MEM_BYTES = (2 ** BLOCK_ADDR_W) * BLOCK_BYTES;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  // Handshake: read is a level request held by the cache until busywait falls; busywait
  // rises one cycle after read is first seen in IDLE, stays high exactly LATENCY cycles,
  // and readdata is valid in the cycle it falls. read must drop for one edge before reuse.

  state_t                     state_q, state_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic [BLOCK_ADDR_W-1:0]    blk_q, blk_d;
  logic                       busy_q, busy_d;
  logic [8*BLOCK_BYTES-1:0]   rdata_q, rdata_d;
  logic                       lerr_q, lerr_d;
  logic                       load_ok;
  logic [8*BLOCK_BYTES-1:0]   blk_data;
  logic [7:0]                 mem [0:MEM_BYTES-1];

  assign load_ok = (state_q == IDLE) && !read;

  always_comb begin
    blk_data = '0;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      blk_data[8*i +: 8] = mem[{blk_q, 4'(i)}];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    busy_d  = busy_q;
    rdata_d = rdata_q;
    lerr_d  = load_en && !load_ok;
    case (state_q)
      IDLE: begin
        if (read) begin
          blk_d   = address;
          busy_d  = 1'b1;
          cnt_d   = 8'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          rdata_d = blk_data;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!read) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
      lerr_q  <= lerr_d;
    end
  end

  // The array survives reset; loads only land while idle, so an in-flight block is never touched.
  always_ff @(posedge clock) begin
    if (load_en && load_ok) mem[load_addr] <= load_data;
  end

  assign readdata  = rdata_q;
  assign busywait  = busy_q;
  assign load_err  = lerr_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Directed-plus-random bench for instruction_memory_responder: a byte-array reference model
// predicts every returned block, busy-pulse length and load rejection.
module tb_instruction_memory_responder;

  localparam int LAT = 40;

  logic         clock = 1'b0;
  logic         reset;
  logic         read, load_en;
  logic [5:0]   address;
  logic [9:0]   load_addr;
  logic [7:0]   load_data;
  logic [127:0] readdata;
  logic         busywait, load_err;
  logic [1:0]   state_dbg;

  logic         read1, load_en1;
  logic [5:0]   address1;
  logic [9:0]   load_addr1;
  logic [7:0]   load_data1;
  logic [127:0] readdata1;
  logic         busywait1, load_err1;
  logic [1:0]   state_dbg1;

  logic [7:0]   ref_mem  [0:1023];
  logic [7:0]   ref_mem1 [0:1023];
  int           n_checks = 0;
  int           n_pass   = 0;

  always #5 clock = ~clock;

  instruction_memory_responder #(.LATENCY(LAT), .BLOCK_ADDR_W(6), .BLOCK_BYTES(16)) u_dut (
    .clock(clock), .reset(reset), .read(read), .address(address), .readdata(readdata),
    .busywait(busywait), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .load_err(load_err), .state_dbg(state_dbg));

  instruction_memory_responder #(.LATENCY(1), .BLOCK_ADDR_W(6), .BLOCK_BYTES(16)) u_dut1 (
    .clock(clock), .reset(reset), .read(read1), .address(address1), .readdata(readdata1),
    .busywait(busywait1), .load_en(load_en1), .load_addr(load_addr1), .load_data(load_data1),
    .load_err(load_err1), .state_dbg(state_dbg1));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] exp_block(input logic [5:0] a);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_mem[{a, 4'(i)}];
    return r;
  endfunction

  task automatic load0(input logic [9:0] a, input logic [7:0] d, input bit expect_ok);
    @(negedge clock);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clock);
    load_en = 1'b0;
    check("load_err", {127'd0, load_err}, {127'd0, !expect_ok});
    if (expect_ok) ref_mem[a] = d;
  endtask

  // One full request: optional address change and rejected load while busy.
  task automatic fetch(input logic [5:0] a, input bit sw, input bit bl);
    logic [127:0] e;
    int cnt;
    e = exp_block(a);
    @(negedge clock);
    read = 1'b1; address = a;
    @(negedge clock);
    check("busy_rise", {127'd0, busywait}, 128'd1);
    cnt = 1;
    while (busywait === 1'b1 && cnt < 300) begin
      if (sw && cnt == 3) address = 6'h3F;
      if (bl && cnt == 5) begin
        load_en = 1'b1; load_addr = 10'h055; load_data = ~ref_mem[10'h055];
      end
      @(negedge clock);
      if (bl && cnt == 5) begin
        check("busy_load_err", {127'd0, load_err}, 128'd1);
        load_en = 1'b0;
      end
      if (busywait === 1'b1) cnt++;
    end
    check("busy_len", 128'(cnt), 128'(LAT));
    check("rdata", readdata, e);
    repeat (3) begin
      @(negedge clock);
      check("done_hold_busy", {127'd0, busywait}, 128'd0);
    end
    check("done_hold_rdata", readdata, e);
    read = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    logic [127:0] e1;
    reset = 1'b1; read = 1'b0; address = '0; load_en = 1'b0; load_addr = '0; load_data = '0;
    read1 = 1'b0; address1 = '0; load_en1 = 1'b0; load_addr1 = '0; load_data1 = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", {127'd0, busywait}, 128'd0);
    check("rst_rdata", readdata, 128'd0);
    check("rst_lerr", {127'd0, load_err}, 128'd0);
    reset = 1'b0;

    for (int a = 0; a < 1024; a++) load0(10'(a), 8'($urandom), 1'b1);
    for (int i = 0; i < 16; i++) load0(10'h050 + 10'(i), 8'(i), 1'b1);

    fetch(6'h05, 1'b0, 1'b0);
    check("word0", {96'd0, readdata[31:0]}, 128'h03020100);
    check("blk5_const", readdata, 128'h0F0E0D0C0B0A09080706050403020100);
    fetch(6'h05, 1'b0, 1'b0);
    fetch(6'h05, 1'b1, 1'b1);
    fetch(6'h3F, 1'b0, 1'b0);
    load0(10'h055, 8'hA5, 1'b1);
    fetch(6'h05, 1'b0, 1'b0);

    repeat (4) begin
      load0(10'($urandom_range(0, 1023)), 8'($urandom), 1'b1);
      fetch(6'($urandom_range(0, 63)), 1'($urandom), 1'($urandom));
    end

    // Reset in the middle of a request aborts it asynchronously.
    @(negedge clock);
    read = 1'b1; address = 6'h05;
    repeat (10) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", {127'd0, busywait}, 128'd0);
    check("midrst_rdata", readdata, 128'd0);
    @(negedge clock);
    reset = 1'b0; read = 1'b0;
    fetch(6'h05, 1'b0, 1'b0);

    // LATENCY=1 instance.
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      load_en1 = 1'b1; load_addr1 = {6'h2A, 4'(i)}; load_data1 = 8'($urandom);
      ref_mem1[{6'h2A, 4'(i)}] = load_data1;
      @(negedge clock);
      load_en1 = 1'b0;
    end
    for (int i = 0; i < 16; i++) e1[8*i +: 8] = ref_mem1[{6'h2A, 4'(i)}];
    @(negedge clock);
    read1 = 1'b1; address1 = 6'h2A;
    @(negedge clock);
    check("lat1_busy_high", {127'd0, busywait1}, 128'd1);
    @(negedge clock);
    check("lat1_busy_low", {127'd0, busywait1}, 128'd0);
    check("lat1_rdata", readdata1, e1);
    read1 = 1'b0;
    @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
